// File: rtl/crc_arb_pkg.sv
// Shared types and helpers for the CRC job arbiter.
// Holds the FSM states, engine register map and byte-enable encoding.
package crc_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        INIT,
        DATA,
        RDREQ,
        RDWAIT,
        DONE
    } state_t;

    localparam logic [2:0] ADDR_INIT = 3'd0;
    localparam logic [2:0] ADDR_DATA = 3'd1;
    localparam logic [2:0] ADDR_RES  = 3'd4;

    // Only the final word of a job can be partial; lanes fill from lane 0.
    function automatic logic [3:0] be_encode(
        input logic       last,
        input logic [1:0] nbytes
    );
        logic [3:0] be;
        be = 4'b1111;
        if (last) begin
            case (nbytes)
                2'd1:    be = 4'b0001;
                2'd2:    be = 4'b0011;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

endpackage

// File: rtl/crc_job_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above
// the pointer, wrapping; returns one-hot grant and its index.
module crc_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    logic [IW-1:0] w_i;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        int v;
        v     = 0;
        w_i   = '0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            v   = (int'(i_ptr) + k) % NUM_REQ;
            w_i = IW'(v);
            if (i_req[w_i]) begin
                o_gnt      = '0;
                o_gnt[w_i] = 1'b1;
                o_idx      = w_i;
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crc_job_arbiter.sv
// Shares one Avalon CRC engine between NUM_REQ streaming requesters,
// one whole job at a time, round-robin.
module crc_job_arbiter
    import crc_arb_pkg::*;
#(
    parameter int         NUM_REQ   = 2,
    parameter int         MAX_WORDS = 1024,
    parameter int         RD_LAT    = 1,
    parameter logic [2:0] RES_ADDR  = ADDR_RES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      gnt,
    input  logic [32*NUM_REQ-1:0]   s_data,
    input  logic [NUM_REQ-1:0]      s_valid,
    input  logic [NUM_REQ-1:0]      s_last,
    input  logic [2*NUM_REQ-1:0]    s_bytes,
    output logic [NUM_REQ-1:0]      s_ready,
    output logic [31:0]             res_data,
    output logic [NUM_REQ-1:0]      res_valid,
    output logic                    res_err,
    output logic                    busy,
    output logic [2:0]              crc_address,
    output logic [31:0]             crc_writedata,
    output logic [3:0]              crc_byteenable,
    output logic                    crc_write,
    output logic                    crc_read,
    output logic                    crc_chipselect,
    input  logic [31:0]             crc_readdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_WORDS + 1);

    state_t             r_state;
    state_t             w_next;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic [CW-1:0]      r_cnt;
    logic               r_err;
    logic [1:0]         r_lat;
    logic [31:0]        r_res;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [IW-1:0]      w_arb_idx;
    logic               w_arb_any;
    logic [31:0]        w_own_data;
    logic               w_own_valid;
    logic               w_own_last;
    logic [1:0]         w_own_bytes;
    logic               w_accept;
    logic [CW-1:0]      w_cnt_inc;
    logic               w_max;
    logic               w_rd;
    logic               w_lat_done;

    crc_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    assign w_own_data  = s_data[32*r_owner +: 32];
    assign w_own_valid = s_valid[r_owner];
    assign w_own_last  = s_last[r_owner];
    assign w_own_bytes = s_bytes[2*r_owner +: 2];
    assign w_accept    = (r_state == DATA) && w_own_valid;
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_max       = (w_cnt_inc == CW'(MAX_WORDS));
    assign w_rd        = (r_state == RDREQ) || (r_state == RDWAIT);
    // r_lat counts read cycles already spent, starting at RDREQ.
    assign w_lat_done  = (r_lat == 2'(RD_LAT - 1));

    assign gnt      = r_gnt;
    assign res_data = r_res;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        s_ready        = '0;
        res_valid      = '0;
        res_err        = 1'b0;
        busy           = (r_state != IDLE) && (r_state != ARB);
        crc_address    = '0;
        crc_writedata  = '0;
        crc_byteenable = '0;
        crc_write      = 1'b0;
        crc_read       = 1'b0;
        crc_chipselect = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|req) w_next = ARB;
            end
            ARB: begin
                w_next = w_arb_any ? INIT : IDLE;
            end
            INIT: begin
                crc_chipselect = 1'b1;
                crc_write      = 1'b1;
                crc_address    = ADDR_INIT;
                crc_byteenable = 4'b1111;
                w_next         = DATA;
            end
            DATA: begin
                s_ready[r_owner] = 1'b1;
                if (w_own_valid) begin
                    crc_chipselect = 1'b1;
                    crc_write      = 1'b1;
                    crc_address    = ADDR_DATA;
                    crc_writedata  = w_own_data;
                    crc_byteenable = be_encode(w_own_last, w_own_bytes);
                    if (w_own_last || w_max) w_next = RDREQ;
                end
            end
            RDREQ, RDWAIT: begin
                crc_chipselect = 1'b1;
                crc_read       = 1'b1;
                crc_address    = RES_ADDR;
                w_next         = w_lat_done ? DONE : RDWAIT;
            end
            DONE: begin
                res_valid = r_gnt;
                res_err   = r_err;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_owner <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_lat   <= '0;
            r_res   <= '0;
        end else begin
            if ((r_state == ARB) && w_arb_any) begin
                r_owner <= w_arb_idx;
                r_gnt   <= w_arb_gnt;
            end
            if (w_accept) r_cnt <= w_cnt_inc;
            if (w_accept && !w_own_last && w_max) r_err <= 1'b1;
            if (w_rd) r_lat <= r_lat + 1'b1;
            if (w_rd && w_lat_done) r_res <= crc_readdata;
            if (r_state == DONE) begin
                r_ptr <= (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                r_gnt <= '0;
                r_cnt <= '0;
                r_err <= 1'b0;
                r_lat <= '0;
            end
        end
    end

endmodule

// File: tb/tb_crc_job_arbiter.sv
// Bench for crc_job_arbiter: requester agents, a CRC-32 engine model
// and a scoreboard fed with byte-level CRCs of each submitted job.
module tb_crc_job_arbiter;

    localparam int NR   = 2;
    localparam int MAXW = 4;

    typedef struct packed {
        logic [3:0]       n;
        logic [7:0][31:0] w;
        logic [1:0]       nbytes;
        logic             nolast;
        logic [7:0]       vpat;
        logic [3:0]       plen;
    } job_t;

    typedef struct packed {
        logic [2:0]  own;
        logic [31:0] crc;
        logic        err;
        logic [3:0]  nwr;
        logic [3:0]  be;
        logic [3:0]  lat;
        logic        haslit;
        logic [31:0] lit;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic [NR-1:0]    req, gnt, s_valid, s_last, s_ready, res_valid;
    logic [32*NR-1:0] s_data;
    logic [2*NR-1:0]  s_bytes;
    logic [31:0] res_data, crc_writedata, crc_readdata;
    logic res_err, busy, crc_write, crc_read, crc_chipselect;
    logic [2:0] crc_address;
    logic [3:0] crc_byteenable;

    logic        a_req[NR];
    logic        a_val[NR];
    logic        a_last[NR];
    logic [31:0] a_data[NR];
    logic [1:0]  a_bytes[NR];
    int          rise[NR];

    job_t jq0[$];
    job_t jq1[$];
    exp_t expq[$];

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int tmo_req;
    bit end_req;
    bit end_ack = 0;
    logic rst_d = 1'b0;
    logic [31:0] eng_crc = 32'h0;
    logic [3:0]  eng_nwr = 4'd0;
    logic [3:0]  eng_be = 4'd0;

    crc_job_arbiter #(
        .NUM_REQ   (NR),
        .MAX_WORDS (MAXW),
        .RD_LAT    (1),
        .RES_ADDR  (3'd4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .gnt            (gnt),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_last         (s_last),
        .s_bytes        (s_bytes),
        .s_ready        (s_ready),
        .res_data       (res_data),
        .res_valid      (res_valid),
        .res_err        (res_err),
        .busy           (busy),
        .crc_address    (crc_address),
        .crc_writedata  (crc_writedata),
        .crc_byteenable (crc_byteenable),
        .crc_write      (crc_write),
        .crc_read       (crc_read),
        .crc_chipselect (crc_chipselect),
        .crc_readdata   (crc_readdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        req     = '0;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        s_bytes = '0;
        for (int k = 0; k < NR; k++) begin
            req[k]            = a_req[k];
            s_valid[k]        = a_val[k];
            s_last[k]         = a_last[k];
            s_data[32*k +: 32] = a_data[k];
            s_bytes[2*k +: 2]  = a_bytes[k];
        end
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    // Engine: INIT presets, DATA folds enabled lanes in order, RES reads ~crc.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= !reset_n;
        if (crc_chipselect && crc_write && crc_address == 3'd0) begin
            eng_crc <= 32'hFFFFFFFF;
            eng_nwr <= 4'd0;
        end else if (crc_chipselect && crc_write && crc_address == 3'd1) begin
            logic [31:0] c;
            c = eng_crc;
            for (int b = 0; b < 4; b++)
                if (crc_byteenable[b]) c = crc_byte(c, crc_writedata[8*b +: 8]);
            eng_crc <= c;
            eng_nwr <= eng_nwr + 4'd1;
            eng_be  <= crc_byteenable;
        end
    end

    assign crc_readdata = (crc_chipselect && crc_read && crc_address == 3'd4)
                          ? ~eng_crc : 32'hDEADBEEF;

    function automatic job_t mkjob(input int n, input logic [31:0] w0, input logic [31:0] w1,
                                   input logic [31:0] w2, input logic [31:0] w3,
                                   input logic [1:0] nb, input bit nl,
                                   input logic [7:0] vp, input int pl);
        job_t j;
        j = '0;
        j.n = 4'(n);
        j.w[0] = w0; j.w[1] = w1; j.w[2] = w2; j.w[3] = w3;
        j.w[4] = ~w0; j.w[5] = ~w1;
        j.nbytes = nb;
        j.nolast = nl;
        j.vpat = vp;
        j.plen = 4'(pl);
        return j;
    endfunction

    // Reference: CRC-32 over the bytes the requester meant to send.
    function automatic logic [31:0] job_crc(input job_t j, input int nw);
        logic [31:0] c;
        int nb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < nw; i++) begin
            nb = 4;
            if (i == nw - 1 && !j.nolast) nb = (j.nbytes == 2'd1) ? 1 : (j.nbytes == 2'd2) ? 2 : 4;
            for (int b = 0; b < nb; b++) c = crc_byte(c, j.w[i][8*b +: 8]);
        end
        return ~c;
    endfunction

    task automatic launch(input int r, input job_t j, input int lat, input bit expect_res,
                          input logic [31:0] lit, input bit haslit);
        exp_t e;
        int nw;
        nw = j.nolast ? MAXW : int'(j.n);
        e = '0;
        e.own = 3'(r);
        e.crc = job_crc(j, nw);
        e.err = j.nolast;
        e.nwr = 4'(nw);
        e.be = j.nolast ? 4'b1111 : (j.nbytes == 2'd1) ? 4'b0001 : (j.nbytes == 2'd2) ? 4'b0011 : 4'b1111;
        e.lat = 4'(lat);
        e.haslit = haslit;
        e.lit = lit;
        if (expect_res) expq.push_back(e);
        if (r == 0) jq0.push_back(j);
        else jq1.push_back(j);
    endtask

    task automatic drive(input int r, input job_t j, input int idx, input int pi);
        if (idx < int'(j.n)) begin
            a_val[r]   = (pi < int'(j.plen)) ? j.vpat[pi] : 1'b1;
            a_data[r]  = j.w[idx];
            a_last[r]  = !j.nolast && (idx == int'(j.n) - 1);
            a_bytes[r] = a_last[r] ? j.nbytes : 2'd0;
        end else begin
            a_val[r]  = 1'b0;
            a_last[r] = 1'b0;
        end
    endtask

    task automatic agent(input int r);
        job_t j;
        int idx, pi, guard;
        bit got;
        a_req[r] = 0; a_val[r] = 0; a_last[r] = 0; a_data[r] = '0; a_bytes[r] = '0;
        forever begin
            @(posedge clk); #1;
            got = 0;
            if (r == 0 && jq0.size() > 0) begin j = jq0.pop_front(); got = 1; end
            if (r == 1 && jq1.size() > 0) begin j = jq1.pop_front(); got = 1; end
            if (!got) begin a_req[r] = 0; continue; end
            if (!a_req[r]) rise[r] = cyc;
            a_req[r] = 1;
            idx = 0; pi = 0; guard = 0;
            forever begin
                drive(r, j, idx, pi);
                @(negedge clk);
                if (!reset_n || res_valid[r] || guard > 400) break;
                if (s_ready[r]) begin
                    if (a_val[r]) idx++;
                    pi++;
                end
                guard++;
                @(posedge clk); #1;
            end
            a_val[r] = 0;
            a_last[r] = 0;
        end
    endtask

    initial agent(0);
    initial agent(1);

    task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %h required %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    initial begin : compare
        exp_t e;
        bit first;
        int tmo_seen;
        first = 1;
        tmo_seen = 0;
        forever begin
            @(negedge clk);
            if (first) begin
                first = 0;
                chk("model_123456789", job_crc(mkjob(3, 32'h34333231, 32'h38373635, 32'h39, 0, 2'd1, 0, 0, 0), 3) == 32'hCBF43926,
                    64'(job_crc(mkjob(3, 32'h34333231, 32'h38373635, 32'h39, 0, 2'd1, 0, 0, 0), 3)), 64'hCBF43926);
                chk("model_zero4", job_crc(mkjob(1, 0, 0, 0, 0, 2'd0, 0, 0, 0), 1) == 32'h2144DF1C,
                    64'(job_crc(mkjob(1, 0, 0, 0, 0, 2'd0, 0, 0, 0), 1)), 64'h2144DF1C);
            end
            if (rst_d) begin
                chk("reset_outputs",
                    {gnt, s_ready, res_valid, res_err, busy, crc_write, crc_read, crc_chipselect, crc_address, crc_byteenable} === '0
                    && crc_writedata === 32'h0,
                    64'({gnt, s_ready, res_valid, res_err, busy, crc_write, crc_read, crc_chipselect, crc_address, crc_byteenable}), 64'h0);
                chk("reset_res_data", res_data === 32'h0, 64'(res_data), 64'h0);
            end
            chk("gnt_onehot0", $onehot0(gnt) && !$isunknown(gnt), 64'(gnt), 64'h0);
            chk("ready_owner_only", (s_ready & ~gnt) === '0, 64'(s_ready), 64'(gnt));
            chk("no_write_and_read", !(crc_write && crc_read), 64'({crc_write, crc_read}), 64'h0);
            if (gnt === '0)
                chk("quiet_when_idle", {crc_write, crc_read, crc_chipselect} === 3'b000,
                    64'({crc_write, crc_read, crc_chipselect}), 64'h0);
            else
                chk("busy_with_gnt", busy === 1'b1, 64'(busy), 64'h1);
            if (res_valid !== '0) begin
                if (expq.size() == 0) begin
                    chk("unexpected_res_valid", 0, 64'(res_valid), 64'h0);
                end else begin
                    e = expq.pop_front();
                    chk("res_owner", res_valid === (NR'(1) << e.own), 64'(res_valid), 64'(NR'(1) << e.own));
                    chk("res_data", res_data === e.crc, 64'(res_data), 64'(e.crc));
                    if (e.haslit) chk("res_data_literal", res_data === e.lit, 64'(res_data), 64'(e.lit));
                    chk("res_err", res_err === e.err, 64'(res_err), 64'(e.err));
                    chk("data_writes", eng_nwr === e.nwr, 64'(eng_nwr), 64'(e.nwr));
                    chk("last_byteenable", eng_be === e.be, 64'(eng_be), 64'(e.be));
                    if (e.lat != 0)
                        chk("latency", (cyc - rise[e.own]) == int'(e.lat), 64'(cyc - rise[e.own]), 64'(e.lat));
                end
            end
            if (tmo_req != tmo_seen) begin
                chk("timeout", 0, 64'(tmo_req), 64'(tmo_seen));
                tmo_seen = tmo_req;
            end
            if (end_req && !end_ack) begin
                chk("all_results_seen", expq.size() == 0, 64'(expq.size()), 64'h0);
                end_ack = 1;
            end
        end
    end

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while ((expq.size() != 0 || jq0.size() != 0 || jq1.size() != 0 || busy) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= budget) tmo_req++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int k;
        reset_n = 1'b0;
        tmo_req = 0;
        end_req = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        launch(0, mkjob(3, 32'h34333231, 32'h38373635, 32'h00000039, 0, 2'd1, 0, 0, 0), 7, 1, 32'hCBF43926, 1);
        wait_done(100);
        launch(1, mkjob(1, 0, 0, 0, 0, 2'd0, 0, 0, 0), 5, 1, 32'h2144DF1C, 1);
        wait_done(100);

        for (int i = 0; i < 2; i++) begin
            launch(0, mkjob(2, 32'h11223344 + i, 32'hA5A5A5A5, 0, 0, 2'd0, 0, 0, 0), 0, 1, 0, 0);
            launch(1, mkjob(2, 32'hCAFEF00D, 32'h00BEEF00 + i, 0, 0, 2'd2, 0, 0, 0), 0, 1, 0, 0);
        end
        wait_done(300);

        launch(0, mkjob(2, 32'h64636261, 32'h00006665, 0, 0, 2'd2, 0, 0, 0), 0, 1, 0, 0);
        wait_done(100);
        launch(1, mkjob(2, 32'h64636261, 32'h00006665, 0, 0, 2'd2, 0, 8'b00001001, 4), 0, 1, 0, 0);
        wait_done(100);

        launch(0, mkjob(6, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 2'd0, 1, 0, 0), 0, 1, 0, 0);
        wait_done(100);
        launch(1, mkjob(1, 32'h87654321, 0, 0, 0, 2'd0, 0, 0, 0), 5, 1, 0, 0);
        wait_done(100);
        launch(0, mkjob(4, 32'hDEADBEEF, 32'h0BADF00D, 32'h13579BDF, 32'h2468ACE0, 2'd3, 0, 0, 0), 8, 1, 0, 0);
        wait_done(100);

        launch(0, mkjob(4, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 2'd0, 0, 0, 0), 0, 0, 0, 0);
        k = 0;
        while (!(s_ready[0] === 1'b1 && eng_nwr >= 4'd2) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) tmo_req++;
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        launch(0, mkjob(3, 32'h34333231, 32'h38373635, 32'h00000039, 0, 2'd1, 0, 0, 0), 7, 1, 32'hCBF43926, 1);
        wait_done(100);

        end_req = 1;
        k = 0;
        while (!end_ack && k < 20) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/crc_job_arbiter.md
Name: crc_job_arbiter

Overview:
Shares one CRC_Component engine (Avalon-slave register interface) between NUM_REQ streaming requesters. Grants the engine round-robin, one whole job at a time. For each job it issues the init write, streams data words with correct byte enables, reads back the 32-bit result, and returns it to the owning requester. Sits between hardware accelerators/DMA clients and the single shared CRC engine.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MAX_WORDS, 1024, job word limit; reaching it without last aborts the job with an error
RD_LAT, 1, cycles from crc_read assertion to valid crc_readdata (1..3)
RES_ADDR, 3'd4, engine address read for the final CRC

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
req  in  NUM_REQ  job request per requester; level, held until res_valid
gnt  out  NUM_REQ  one-hot current owner; all zero when idle
s_data  in  32*NUM_REQ  data word per requester; byte lane 0 is the first byte
s_valid  in  NUM_REQ  data word valid
s_last  in  NUM_REQ  final word of the job
s_bytes  in  2*NUM_REQ  valid bytes in the last word: 0=4, 1=1, 2=2, 3 treated as 4
s_ready  out  NUM_REQ  word accepted when s_valid&s_ready; only the owner's bit can be set
res_data  out  32  CRC result; held until the next result
res_valid  out  NUM_REQ  1-cycle pulse on the owner's bit
res_err  out  1  valid with res_valid; 1 = MAX_WORDS abort
busy  out  1  a job is in progress
crc_address  out  3  engine address
crc_writedata  out  32  engine write data
crc_byteenable  out  4  engine byte enables
crc_write  out  1  engine write strobe
crc_read  out  1  engine read strobe
crc_chipselect  out  1  engine select
crc_readdata  in  32  engine read data

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; all outputs 0; RR pointer=0; word counter=0. Applies mid-job: the job is dropped silently and no res_valid is issued. Engine state is not cleared, which is harmless because every job starts with INIT.
- IDLE: if any req, go to ARB next cycle; else stay.
- ARB (1 cycle):
  - Search starts at RR pointer, upward with wrap. The first set req becomes owner; gnt is registered from the next cycle.
  - If req has dropped to zero, return to IDLE.
- INIT (1 cycle): crc_chipselect=1, crc_write=1, crc_address=0, crc_byteenable=4'b1111, crc_writedata=0. Next state DATA.
- DATA:
  - s_ready[owner]=1.
  - On s_valid[owner]: crc_write=1, crc_address=1, crc_writedata=s_data[owner].
  - crc_byteenable is 1111 for non-last words. For the last word it follows s_bytes: 0001, 0011 or 1111.
  - Counter increments on every accepted word.
  - Accepted s_last goes to RDREQ.
  - If the counter reaches MAX_WORDS on a non-last word, set the error flag and go to RDREQ. s_ready drops from that cycle on.
  - Without s_valid there is no write and the block stalls indefinitely.
- RDREQ (1 cycle): crc_chipselect=1, crc_read=1, crc_address=RES_ADDR. Next state RDWAIT.
- RDWAIT: hold read/address/chipselect for RD_LAT cycles total, counting from RDREQ. Capture crc_readdata into res_data on the RD_LAT-th edge. Next state DONE.
- DONE (1 cycle):
  - res_valid[owner]=1, res_err=error flag.
  - RR pointer = owner+1 mod NUM_REQ; clear error flag and counter; gnt=0; go to IDLE.
- gnt is held from INIT through DONE. Owner req dropping mid-job is ignored; the job completes.
- A non-owner's s_valid is never accepted; its s_ready is 0.
- crc_write, crc_read and crc_chipselect are 0 in IDLE and ARB. crc_write and crc_read are never asserted together.
- Latency: a 1-word job with RD_LAT=1 gives req at cycle 0, then ARB 1, INIT 2, DATA 3, RDREQ 4, DONE 5 with res_valid at cycle 5. Each added word (valid every cycle) adds 1 cycle.
- Back-to-back jobs: DONE → IDLE → ARB, a 2-cycle bubble minimum.

Decomposition:
- Shared package crc_arb_pkg holds:
  - state enum (IDLE, ARB, INIT, DATA, RDREQ, RDWAIT, DONE)
  - engine address constants: ADDR_INIT=0, ADDR_DATA=1, ADDR_RES=4
  - byteenable encode function
- One sub-module, crc_rr_arbiter: combinational round-robin pick from req and pointer, output one-hot plus index.

Test Plan:
1. Req0 alone sends words 0x34333231, 0x38373635, then last 0x00000039 with s_bytes=1 → res_data=0xCBF43926, res_valid[0] pulse, res_err=0, crc_byteenable of last write = 0001.
2. Single word 0x00000000 with s_bytes=0 from req1 → res_valid[1] exactly 5 cycles after req rise (RD_LAT=1); res_data matches the reference model (CRC-32 of 4 zero bytes = 0x2144DF1C).
3. req0 and req1 asserted continuously with repeated 2-word jobs → grants alternate 0,1,0,1; gnt[1] never set while gnt[0] is set; each res_valid goes to the correct owner.
4. Owner s_valid toggles 1-0-0-1 (last) → exactly 2 crc_write data strobes; the stall does not advance the counter; result equals the gapless case.
5. MAX_WORDS=4, requester never asserts s_last → 4 words accepted, s_ready falls, res_valid with res_err=1, next job grant proceeds normally.
6. reset_n pulled low in DATA after 2 words → next cycle all outputs 0, no res_valid; a subsequent job produces the correct CRC (INIT clears stale engine state).
